// File: rtl/audio_mixer.sv
// audio_mixer: N-source stereo mixer with its own sample-rate tick generator.
// Each tick snapshots every source, accumulates one source per cycle through a
// single multiplier per channel, applies master volume, saturates to DW bits
// and presents the result with a one-cycle out_valid pulse.
module audio_mixer #(
    parameter int NUM_SRC = 4,
    parameter int DW      = 16,
    parameter int VOL_W   = 4,
    parameter int DIV_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic [NUM_SRC*DW-1:0]    src_left,
    input  logic [NUM_SRC*DW-1:0]    src_right,
    input  logic [NUM_SRC*VOL_W-1:0] src_vol,
    input  logic [NUM_SRC-1:0]       src_mute,
    input  logic [VOL_W-1:0]         master_vol,
    input  logic                     clip_clr,
    output logic                     next_sample,
    output logic [DW-1:0]            left_out,
    output logic [DW-1:0]            right_out,
    output logic                     out_valid,
    output logic                     clip_l,
    output logic                     clip_r,
    output logic                     overrun
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // Accumulator is wide enough that summing NUM_SRC scaled sources never wraps.
    localparam int ACC_W = DW + VOL_W + $clog2(NUM_SRC) + 1;
    // Master-scaled product width: accumulator times an unsigned VOL_W value.
    localparam int M_W   = ACC_W + VOL_W + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_SRC - 1);
    localparam logic signed [M_W-1:0] SAT_MAX  = {{(M_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [M_W-1:0] SAT_MIN  = {{(M_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2
    } state_t;

    // One source's contribution: (sample * volume) >>> (VOL_W-1), or zero when muted.
    function automatic logic signed [ACC_W-1:0] src_term(
        input logic [DW-1:0]    s,
        input logic [VOL_W-1:0] v,
        input logic             m
    );
        logic signed [ACC_W-1:0] s_ext;
        logic signed [ACC_W-1:0] v_ext;
        logic signed [ACC_W-1:0] prod;
        s_ext = {{(ACC_W-DW){s[DW-1]}}, s};
        v_ext = {{(ACC_W-VOL_W){1'b0}}, v};
        prod  = s_ext * v_ext;
        if (m) begin
            return {ACC_W{1'b0}};
        end else begin
            return prod >>> (VOL_W - 1);
        end
    endfunction

    // Master volume applied to a channel accumulator.
    function automatic logic signed [M_W-1:0] master_scale(
        input logic signed [ACC_W-1:0] a,
        input logic [VOL_W-1:0]        mv
    );
        logic signed [M_W-1:0] a_ext;
        logic signed [M_W-1:0] mv_ext;
        logic signed [M_W-1:0] prod;
        a_ext  = {{(M_W-ACC_W){a[ACC_W-1]}}, a};
        mv_ext = {{(M_W-VOL_W){1'b0}}, mv};
        prod   = a_ext * mv_ext;
        return prod >>> (VOL_W - 1);
    endfunction

    // Clamp to the DW-bit signed range; MSB of the result flags that clamping occurred.
    function automatic logic [DW:0] saturate(input logic signed [M_W-1:0] m);
        if (m > SAT_MAX) begin
            return {1'b1, SAT_MAX[DW-1:0]};
        end else if (m < SAT_MIN) begin
            return {1'b1, SAT_MIN[DW-1:0]};
        end else begin
            return {1'b0, m[DW-1:0]};
        end
    endfunction

    logic [DIV_W-1:0]         cnt_r;
    logic                     next_sample_r;
    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [IDX_W-1:0]         idx_r;
    logic [NUM_SRC*DW-1:0]    snap_left_r;
    logic [NUM_SRC*DW-1:0]    snap_right_r;
    logic [NUM_SRC*VOL_W-1:0] snap_vol_r;
    logic [NUM_SRC-1:0]       snap_mute_r;
    logic [VOL_W-1:0]         snap_master_r;
    logic signed [ACC_W-1:0]  acc_left_r;
    logic signed [ACC_W-1:0]  acc_right_r;
    logic signed [ACC_W-1:0]  term_left_s;
    logic signed [ACC_W-1:0]  term_right_s;
    logic signed [M_W-1:0]    mix_left_s;
    logic signed [M_W-1:0]    mix_right_s;
    logic [DW:0]              sat_left_s;
    logic [DW:0]              sat_right_s;
    logic [DW-1:0]            left_out_r;
    logic [DW-1:0]            right_out_r;
    logic                     out_valid_r;
    logic                     clip_left_r;
    logic                     clip_right_r;
    logic                     overrun_r;

    // Sample-rate divider: reload on zero and emit a one-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= {DIV_W{1'b0}};
            next_sample_r <= 1'b0;
        end else if (cnt_r == {DIV_W{1'b0}}) begin
            cnt_r         <= rate_div;
            next_sample_r <= 1'b1;
        end else begin
            cnt_r         <= cnt_r - DIV_W'(1);
            next_sample_r <= 1'b0;
        end
    end

    // Mixer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a tick starts a mix only from IDLE; others are dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (next_sample_r) begin
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_SCALE;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_SCALE: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Per-cycle arithmetic: current source term, master scaling and saturation.
    always_comb begin
        term_left_s  = src_term(snap_left_r[int'(idx_r)*DW +: DW],
                                snap_vol_r[int'(idx_r)*VOL_W +: VOL_W], snap_mute_r[idx_r]);
        term_right_s = src_term(snap_right_r[int'(idx_r)*DW +: DW],
                                snap_vol_r[int'(idx_r)*VOL_W +: VOL_W], snap_mute_r[idx_r]);
        mix_left_s   = master_scale(acc_left_r, snap_master_r);
        mix_right_s  = master_scale(acc_right_r, snap_master_r);
        sat_left_s   = saturate(mix_left_s);
        sat_right_s  = saturate(mix_right_s);
    end

    // Snapshot on an accepted tick, then accumulate one source per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r         <= {IDX_W{1'b0}};
            snap_left_r   <= {(NUM_SRC*DW){1'b0}};
            snap_right_r  <= {(NUM_SRC*DW){1'b0}};
            snap_vol_r    <= {(NUM_SRC*VOL_W){1'b0}};
            snap_mute_r   <= {NUM_SRC{1'b0}};
            snap_master_r <= {VOL_W{1'b0}};
            acc_left_r    <= {ACC_W{1'b0}};
            acc_right_r   <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (next_sample_r) begin
                        snap_left_r   <= src_left;
                        snap_right_r  <= src_right;
                        snap_vol_r    <= src_vol;
                        snap_mute_r   <= src_mute;
                        snap_master_r <= master_vol;
                        acc_left_r    <= {ACC_W{1'b0}};
                        acc_right_r   <= {ACC_W{1'b0}};
                        idx_r         <= {IDX_W{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    acc_left_r  <= acc_left_r + term_left_s;
                    acc_right_r <= acc_right_r + term_right_s;
                    idx_r       <= idx_r + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Output stage: load the saturated mix and pulse out_valid after SCALE.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_out_r  <= {DW{1'b0}};
            right_out_r <= {DW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_r == ST_SCALE);
            if (state_r == ST_SCALE) begin
                left_out_r  <= sat_left_s[DW-1:0];
                right_out_r <= sat_right_s[DW-1:0];
            end
        end
    end

    // Sticky status flags; a set in the same cycle as clip_clr takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_left_r  <= 1'b0;
            clip_right_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if ((state_r == ST_SCALE) && sat_left_s[DW]) begin
                clip_left_r <= 1'b1;
            end else if (clip_clr) begin
                clip_left_r <= 1'b0;
            end
            if ((state_r == ST_SCALE) && sat_right_s[DW]) begin
                clip_right_r <= 1'b1;
            end else if (clip_clr) begin
                clip_right_r <= 1'b0;
            end
            if (next_sample_r && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else if (clip_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign next_sample = next_sample_r;
    assign left_out    = left_out_r;
    assign right_out   = right_out_r;
    assign out_valid   = out_valid_r;
    assign clip_l      = clip_left_r;
    assign clip_r      = clip_right_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_audio_mixer.sv
// Testbench for audio_mixer: timeline reference model checked every cycle,
// plus directed mixes with hand-computed results.
module tb_audio_mixer;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rate_div;
    logic [63:0]   src_left;
    logic [63:0]   src_right;
    logic [15:0]   src_vol;
    logic [3:0]    src_mute;
    logic [3:0]    master_vol;
    logic          clip_clr;
    logic          next_sample;
    logic [15:0]   left_out;
    logic [15:0]   right_out;
    logic          out_valid;
    logic          clip_l;
    logic          clip_r;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_mixer dut (
        .clk(clk), .rst(rst), .rate_div(rate_div),
        .src_left(src_left), .src_right(src_right), .src_vol(src_vol),
        .src_mute(src_mute), .master_vol(master_vol), .clip_clr(clip_clr),
        .next_sample(next_sample), .left_out(left_out), .right_out(right_out),
        .out_valid(out_valid), .clip_l(clip_l), .clip_r(clip_r), .overrun(overrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mix arithmetic straight from the rules: floor-shifted products, sum, master, clamp.
    function automatic void calc_mix(input logic [63:0] s, input logic [15:0] vol,
                                     input logic [3:0] mute, input logic [3:0] mv,
                                     output longint res, output bit clipped);
        longint acc;
        longint t;
        longint m;
        acc = 0;
        for (int i = 0; i < NS; i++) begin
            if (!mute[i]) begin
                t = longint'($signed(s[i*DW +: DW])) * longint'(vol[i*VW +: VW]);
                acc += t >>> 3;
            end
        end
        m = (acc * longint'(mv)) >>> 3;
        if (m > 32767) begin
            res = 32767; clipped = 1'b1;
        end else if (m < -32768) begin
            res = -32768; clipped = 1'b1;
        end else begin
            res = m; clipped = 1'b0;
        end
    endfunction

    bit     model_ok = 1'b0;
    int     mk = 0;
    longint nxt_tick = 0;
    longint out_cyc = -100;
    bit     e_ns = 1'b0, e_valid = 1'b0, e_cl = 1'b0, e_cr = 1'b0, e_ov = 1'b0;
    longint e_l = 0, e_r = 0, pend_l = 0, pend_r = 0;
    bit     pend_cl = 1'b0, pend_cr = 1'b0;

    // Model: expected outputs for the cycle that starts at each rising edge.
    initial begin
        bit busy;
        forever begin
            @(posedge clk);
            mk++;
            if (rst) begin
                e_ns = 0; e_valid = 0; e_l = 0; e_r = 0;
                e_cl = 0; e_cr = 0; e_ov = 0;
                nxt_tick = mk + 1; out_cyc = -100; model_ok = 1'b1;
            end else begin
                // a tick seen in the previous cycle while a mix is in flight is dropped
                busy    = e_ns && (out_cyc >= mk);
                e_valid = (out_cyc == mk);
                if (e_valid) begin
                    e_l = pend_l; e_r = pend_r;
                end
                e_cl = (e_valid && pend_cl) ? 1'b1 : (clip_clr ? 1'b0 : e_cl);
                e_cr = (e_valid && pend_cr) ? 1'b1 : (clip_clr ? 1'b0 : e_cr);
                e_ov = busy ? 1'b1 : (clip_clr ? 1'b0 : e_ov);
                if (e_ns && !busy) begin
                    calc_mix(src_left, src_vol, src_mute, master_vol, pend_l, pend_cl);
                    calc_mix(src_right, src_vol, src_mute, master_vol, pend_r, pend_cr);
                    out_cyc = mk + 5;
                end
                e_ns = (mk == nxt_tick);
                if (e_ns) nxt_tick = mk + rate_div + 1;
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("m_next_sample", next_sample, e_ns);
                chk("m_out_valid", out_valid, e_valid);
                chk("m_left_out", longint'($signed(left_out)), e_l);
                chk("m_right_out", longint'($signed(right_out)), e_r);
                chk("m_clip_l", clip_l, e_cl);
                chk("m_clip_r", clip_r, e_cr);
                chk("m_overrun", overrun, e_ov);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int l0, l1, l2, l3, input int r0, r1, r2, r3);
        src_left  = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
        src_right = {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
    endtask

    task automatic set_vol(input int v0, v1, v2, v3);
        src_vol = {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
    endtask

    // Wait for a tick (snapshotting current inputs), then for out_valid; check latency.
    task automatic run_mix(input string tag);
        bit got;
        int lat;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (next_sample) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk({tag, "_tick_timeout"}, 0, 1);
            return;
        end
        got = 1'b0;
        lat = 0;
        for (int j = 1; j <= 20 && !got; j++) begin
            step();
            if (out_valid) begin
                got = 1'b1;
                lat = j;
            end
        end
        chk({tag, "_latency"}, lat, 6);
    endtask

    initial begin
        bit ns_seen [1:25];
        int hits;
        int pairs;
        bit got;

        rst = 1'b1; rate_div = 8'd9; clip_clr = 1'b0;
        src_left = '0; src_right = '0; src_vol = '0; src_mute = 4'b0000; master_vol = 4'd0;
        step(); step(); step();
        chk("rst_left_out", left_out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_clip_l", clip_l, 0);
        chk("rst_next_sample", next_sample, 0);

        // T1: tick cadence with rate_div=9
        rst = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            step();
            ns_seen[n] = next_sample;
        end
        hits = 0; pairs = 0;
        for (int n = 1; n <= 25; n++) begin
            if (ns_seen[n]) hits++;
            if (n > 1 && ns_seen[n] && ns_seen[n-1]) pairs++;
        end
        chk("t1_tick_c1", ns_seen[1], 1);
        chk("t1_tick_c11", ns_seen[11], 1);
        chk("t1_tick_c21", ns_seen[21], 1);
        chk("t1_tick_count", hits, 3);
        chk("t1_back_to_back", pairs, 0);

        // T2: unity gain sum
        set_src(1000, 2000, -500, 0, -1, -3, 5, 7);
        set_vol(8, 8, 8, 8); master_vol = 4'd8;
        run_mix("t2");
        chk("t2_left", longint'($signed(left_out)), 2500);
        chk("t2_right", longint'($signed(right_out)), 8);
        chk("t2_clip_l", clip_l, 0);

        // T2b: mixed volumes, floor rounding on negatives, master=15
        set_src(-3, 5, -1, 7, 100, 100, 100, 100);
        set_vol(1, 3, 8, 15); master_vol = 4'd15;
        run_mix("t2b");
        chk("t2b_left", longint'($signed(left_out)), 22);
        chk("t2b_right", longint'($signed(right_out)), 630);

        // T3: positive saturation, clear, then set-wins-over-clear
        set_src(30000, 30000, 30000, 30000, 0, 0, 0, 0);
        set_vol(15, 15, 15, 15); master_vol = 4'd8;
        run_mix("t3");
        chk("t3_left", longint'($signed(left_out)), 32767);
        chk("t3_clip_l", clip_l, 1);
        chk("t3_clip_r", clip_r, 0);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("t3_clip_l_cleared", clip_l, 0);
        clip_clr = 1'b1;
        run_mix("t3_setwins");
        clip_clr = 1'b0;
        chk("t3_set_wins", clip_l, 1);

        // T4: negative saturation, then fully muted
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        set_src(-32768, -32768, -32768, -32768, 0, 0, 0, 0);
        set_vol(8, 8, 8, 8); master_vol = 4'd8;
        run_mix("t4");
        chk("t4_left", longint'($signed(left_out)), -32768);
        chk("t4_clip_l", clip_l, 1);
        src_mute = 4'b1111;
        run_mix("t4_mute");
        chk("t4_mute_left", longint'($signed(left_out)), 0);
        chk("t4_clip_sticky", clip_l, 1);
        src_mute = 4'b0000;

        // T5: rate too fast -> overrun; latency is checked by the model each cycle
        rate_div = 8'd3;
        for (int i = 0; i < 40; i++) step();
        chk("t5_overrun", overrun, 1);
        rate_div = 8'd9;
        for (int i = 0; i < 30; i++) step();
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("t5_overrun_cleared", overrun, 0);

        // T6: reset in the middle of ACCUM
        set_src(30000, 30000, 30000, 30000, 0, 0, 0, 0);
        set_vol(15, 15, 15, 15); master_vol = 4'd8;
        run_mix("t6_pre");
        chk("t6_pre_left", longint'($signed(left_out)), 32767);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (next_sample) got = 1'b1;
            else step();
        end
        chk("t6_tick_seen", got, 1);
        step(); step();
        rst = 1'b1;
        step();
        chk("t6_rst_left", left_out, 0);
        chk("t6_rst_clip_l", clip_l, 0);
        chk("t6_rst_valid", out_valid, 0);
        rst = 1'b0;
        step();
        chk("t6_first_tick", next_sample, 1);
        run_mix("t6_post");
        chk("t6_post_left", longint'($signed(left_out)), 32767);

        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
